// File: rtl/pwm_cfg_commit_ctrl.sv
// Two-port arbitrated write scheduler for the PWM configuration bank: writes land in
// shadow registers and are committed to the active outputs only at a PWM period boundary.
module pwm_cfg_commit_ctrl #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic [6:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [6:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  input  logic       period_end,
  input  logic       err_clr,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic [4:0] pending,
  output logic       commit_stb,
  output logic       addr_err
);

  localparam int NREG = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_COMMIT} state_e;
  typedef enum logic {GRANT_A, GRANT_B} grant_e;

  state_e      state_q, state_d;
  grant_e      last_grant_q, last_grant_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  active_q [NREG];
  logic [7:0]  active_d [NREG];
  logic [7:0]  shadow_q [NREG];
  logic [7:0]  shadow_d [NREG];
  logic [4:0]  pending_q, pending_d;
  logic        commit_stb_q, commit_stb_d;
  logic        addr_err_q, addr_err_d;

  logic        wr_en, good_wr, bad_wr, timeout_hit;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;

  // On contention the port that did not win last time is granted.
  assign a_ready = (state_q != ST_COMMIT) && a_valid && (!b_valid || last_grant_q == GRANT_B);
  assign b_ready = (state_q != ST_COMMIT) && b_valid && (!a_valid || last_grant_q == GRANT_A);

  assign wr_en   = a_ready || b_ready;
  assign wr_addr = a_ready ? a_addr : b_addr;
  assign wr_data = a_ready ? a_data : b_data;
  assign good_wr = wr_en && (wr_addr <= 7'd4);
  assign bad_wr  = wr_en && (wr_addr > 7'd4);

  assign timeout_hit = (TIMEOUT_CYCLES != 16'd0) && (cnt_q == TIMEOUT_CYCLES - 16'd1);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (good_wr) begin
          state_d = ST_PENDING;
          cnt_d   = 16'd0;
        end
      end
      ST_PENDING: begin
        cnt_d = cnt_q + 16'd1;
        if (period_end || timeout_hit) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    commit_stb_d = 1'b0;
    last_grant_d = last_grant_q;
    addr_err_d   = addr_err_q;

    if (a_ready)      last_grant_d = GRANT_A;
    else if (b_ready) last_grant_d = GRANT_B;

    if (bad_wr)       addr_err_d = 1'b1;
    else if (err_clr) addr_err_d = 1'b0;

    // Both ports are stalled in COMMIT, so the commit and a shadow write never collide.
    if (state_q == ST_COMMIT) begin
      for (int i = 0; i < NREG; i++) begin
        if (pending_q[i]) active_d[i] = shadow_q[i];
      end
      pending_d    = 5'd0;
      commit_stb_d = 1'b1;
    end

    for (int i = 0; i < NREG; i++) begin
      if (good_wr && wr_addr == 7'(i)) begin
        shadow_d[i]  = wr_data;
        pending_d[i] = 1'b1;
      end
    end
  end

  // NOTE: the register arrays are reset explicitly; their values drive outputs and must be known at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        active_q[i] <= 8'h00;
        shadow_q[i] <= 8'h00;
      end
      pending_q    <= 5'd0;
      commit_stb_q <= 1'b0;
      addr_err_q   <= 1'b0;
      last_grant_q <= GRANT_B;
    end else begin
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      commit_stb_q <= commit_stb_d;
      addr_err_q   <= addr_err_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign en_reg_out_7_0  = active_q[0];
  assign en_reg_out_15_8 = active_q[1];
  assign en_reg_pwm_7_0  = active_q[2];
  assign en_reg_pwm_15_8 = active_q[3];
  assign pwm_duty_cycle  = active_q[4];
  assign pending         = pending_q;
  assign commit_stb      = commit_stb_q;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_pwm_cfg_commit_ctrl.sv
// Directed bench for pwm_cfg_commit_ctrl: default, 10-cycle and disabled timeout
// instances share one stimulus; expected values are hand-computed.
module tb_pwm_cfg_commit_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0, period_end = 1'b0, err_clr = 1'b0;
  logic [6:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_data = '0, b_data = '0;

  logic       a_ready, b_ready, commit_stb, addr_err;
  logic [7:0] r0, r1, r2, r3, r4;
  logic [4:0] pending;
  logic       a_ready_t10, b_ready_t10, commit_stb_t10, addr_err_t10;
  logic [7:0] r0_t10, r1_t10, r2_t10, r3_t10, r4_t10;
  logic [4:0] pending_t10;
  logic       a_ready_t0, b_ready_t0, commit_stb_t0, addr_err_t0;
  logic [7:0] r0_t0, r1_t0, r2_t0, r3_t0, r4_t0;
  logic [4:0] pending_t0;

  wire [39:0] act     = {r0, r1, r2, r3, r4};
  wire [39:0] act_t10 = {r0_t10, r1_t10, r2_t10, r3_t10, r4_t10};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_cfg_commit_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .period_end(period_end), .err_clr(err_clr),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
    .pending(pending), .commit_stb(commit_stb), .addr_err(addr_err)
  );

  pwm_cfg_commit_ctrl #(.TIMEOUT_CYCLES(16'd10)) dut_t10 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready_t10),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready_t10),
    .period_end(period_end), .err_clr(err_clr),
    .en_reg_out_7_0(r0_t10), .en_reg_out_15_8(r1_t10), .en_reg_pwm_7_0(r2_t10),
    .en_reg_pwm_15_8(r3_t10), .pwm_duty_cycle(r4_t10),
    .pending(pending_t10), .commit_stb(commit_stb_t10), .addr_err(addr_err_t10)
  );

  pwm_cfg_commit_ctrl #(.TIMEOUT_CYCLES(16'd0)) dut_t0 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready_t0),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready_t0),
    .period_end(period_end), .err_clr(err_clr),
    .en_reg_out_7_0(r0_t0), .en_reg_out_15_8(r1_t0), .en_reg_pwm_7_0(r2_t0),
    .en_reg_pwm_15_8(r3_t0), .pwm_duty_cycle(r4_t0),
    .pending(pending_t0), .commit_stb(commit_stb_t0), .addr_err(addr_err_t0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 0; b_valid = 0; period_end = 0; err_clr = 0;
    rst_n = 0;
    tick();
    #2 rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    checks++; if (act !== 40'h0) begin errors++; $display("FAIL reset_act: got %h want %h", act, 40'h0); end
    checks++; if (pending !== 5'b0) begin errors++; $display("FAIL reset_pending: got %b want 00000", pending); end
    checks++; if ({commit_stb, addr_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {commit_stb, addr_err}); end
    tick();
    #2 rst_n = 1;
  endtask

  task automatic test_basic_commit();
    a_valid = 1; a_addr = 7'h04; a_data = 8'h80;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL basic_a_ready: got %b want 1", a_ready); end
    tick();
    a_valid = 0;
    checks++; if (pending !== 5'b10000) begin errors++; $display("FAIL basic_pending: got %b want 10000", pending); end
    checks++; if (act !== 40'h0) begin errors++; $display("FAIL basic_not_yet: got %h want %h", act, 40'h0); end
    period_end = 1;
    tick();
    period_end = 0;
    checks++; if ({commit_stb, r4} !== 9'h000) begin errors++; $display("FAIL basic_latency1: got %h want 000", {commit_stb, r4}); end
    tick();
    checks++; if (act !== 40'h00000000_80) begin errors++; $display("FAIL basic_act: got %h want %h", act, 40'h80); end
    checks++; if (commit_stb !== 1'b1) begin errors++; $display("FAIL basic_stb_high: got %b want 1", commit_stb); end
    checks++; if (pending !== 5'b0) begin errors++; $display("FAIL basic_pending_clr: got %b want 00000", pending); end
    tick();
    checks++; if (commit_stb !== 1'b0) begin errors++; $display("FAIL basic_stb_low: got %b want 0", commit_stb); end
  endtask

  task automatic test_arbitration();
    int a_idx = 0;
    int b_idx = 0;
    logic exp_a;
    do_reset();
    for (int cyc = 0; cyc < 8; cyc++) begin
      exp_a = (cyc % 2 == 0);
      a_valid = 1; a_addr = 7'(a_idx); a_data = 8'hA0 + 8'(a_idx);
      b_valid = 1; b_addr = 7'(b_idx); b_data = 8'hB0 + 8'(b_idx);
      #1;
      checks++;
      if ({a_ready, b_ready} !== {exp_a, !exp_a}) begin
        errors++; $display("FAIL arb_grant cycle %0d: got a/b=%b want %b", cyc, {a_ready, b_ready}, {exp_a, !exp_a});
      end
      tick();
      if (exp_a) a_idx++; else b_idx++;
    end
    a_valid = 0; b_valid = 0;
    checks++; if (pending !== 5'b01111) begin errors++; $display("FAIL arb_pending: got %b want 01111", pending); end
    period_end = 1;
    tick();
    period_end = 0;
    a_valid = 1; b_valid = 1; a_addr = 7'h04; b_addr = 7'h04; a_data = 8'h55; b_data = 8'h66;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL arb_commit_stall: got %b want 00", {a_ready, b_ready}); end
    tick();
    a_valid = 0; b_valid = 0;
    checks++; if (act !== 40'hB0B1B2B3_00) begin errors++; $display("FAIL arb_act: got %h want %h", act, 40'hB0B1B2B3_00); end
    checks++; if ({commit_stb, pending} !== 6'b1_00000) begin errors++; $display("FAIL arb_stb_pending: got %b want 100000", {commit_stb, pending}); end
  endtask

  task automatic test_last_write_wins();
    tick();
    a_valid = 1; a_addr = 7'h02; a_data = 8'h11; period_end = 1;
    tick();
    period_end = 0; a_data = 8'h22;
    tick();
    a_valid = 0;
    checks++; if (pending !== 5'b00100) begin errors++; $display("FAIL lww_pending: got %b want 00100", pending); end
    checks++; if ({commit_stb, act} !== {1'b0, 40'hB0B1B2B3_00}) begin errors++; $display("FAIL lww_pe_ignored: got %h want %h", {commit_stb, act}, {1'b0, 40'hB0B1B2B3_00}); end
    tick();
    period_end = 1;
    tick();
    period_end = 0;
    tick();
    checks++; if (act !== 40'hB0B122B3_00) begin errors++; $display("FAIL lww_act: got %h want %h", act, 40'hB0B122B3_00); end
    checks++; if ({commit_stb, pending} !== 6'b1_00000) begin errors++; $display("FAIL lww_stb_pending: got %b want 100000", {commit_stb, pending}); end
  endtask

  task automatic test_addr_err();
    tick();
    b_valid = 1; b_addr = 7'h05; b_data = 8'hFF;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL err_b_ready: got %b want 1", b_ready); end
    tick();
    b_valid = 0;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", addr_err); end
    checks++; if ({pending, act} !== {5'b0, 40'hB0B122B3_00}) begin errors++; $display("FAIL err_no_change: got %h want %h", {pending, act}, {5'b0, 40'hB0B122B3_00}); end
    period_end = 1;
    tick();
    period_end = 0;
    tick();
    checks++; if (commit_stb !== 1'b0) begin errors++; $display("FAIL err_stays_idle: got %b want 0", commit_stb); end
    err_clr = 1; a_valid = 1; a_addr = 7'h7F; a_data = 8'h12;
    tick();
    a_valid = 0;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", addr_err); end
    tick();
    err_clr = 0;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", addr_err); end
    checks++; if (act !== 40'hB0B122B3_00) begin errors++; $display("FAIL err_act: got %h want %h", act, 40'hB0B122B3_00); end
  endtask

  task automatic test_back_to_back();
    period_end = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({commit_stb, pending} !== 6'b0) begin errors++; $display("FAIL b2b_idle cycle %0d: got %b want 000000", k, {commit_stb, pending}); end
    end
    period_end = 0;
    checks++; if (act !== 40'hB0B122B3_00) begin errors++; $display("FAIL b2b_act: got %h want %h", act, 40'hB0B122B3_00); end
  endtask

  task automatic test_timeout();
    logic saw_t0;
    do_reset();
    a_valid = 1; a_addr = 7'h00; a_data = 8'h3C;
    tick();
    a_valid = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (commit_stb_t10 !== (k == 11)) begin errors++; $display("FAIL to10_stb edge+%0d: got %b want %b", k, commit_stb_t10, (k == 11)); end
    end
    checks++; if (act_t10 !== 40'h3C000000_00) begin errors++; $display("FAIL to10_act: got %h want %h", act_t10, 40'h3C000000_00); end
    saw_t0 = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (commit_stb_t0 !== 1'b0) saw_t0 = 1'b1;
    end
    checks++; if (saw_t0 !== 1'b0) begin errors++; $display("FAIL to0_no_commit: got stb seen=%b want 0", saw_t0); end
    checks++; if ({pending_t0, r0_t0} !== {5'b00001, 8'h00}) begin errors++; $display("FAIL to0_pending: got %h want %h", {pending_t0, r0_t0}, {5'b00001, 8'h00}); end
  endtask

  task automatic test_reset_in_commit();
    do_reset();
    a_valid = 1; a_addr = 7'h01; a_data = 8'h5A;
    tick();
    a_valid = 0; period_end = 1;
    tick();
    period_end = 0;
    tick();
    tick();
    checks++; if (act !== 40'h005A0000_00) begin errors++; $display("FAIL rst_pre_act: got %h want %h", act, 40'h005A0000_00); end
    a_valid = 1; a_addr = 7'h03; a_data = 8'h77;
    tick();
    a_valid = 0; period_end = 1;
    tick();
    period_end = 0;
    rst_n = 0;
    #1;
    checks++; if (act !== 40'h0) begin errors++; $display("FAIL rst_commit_act: got %h want %h", act, 40'h0); end
    checks++; if ({commit_stb, pending} !== 6'b0) begin errors++; $display("FAIL rst_commit_pending: got %b want 000000", {commit_stb, pending}); end
    #2 rst_n = 1;
    a_valid = 1; b_valid = 1; a_addr = 7'h00; b_addr = 7'h00; a_data = 8'h01; b_data = 8'h02;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL rst_first_grant: got %b want 10", {a_ready, b_ready}); end
    tick();
    a_valid = 0; b_valid = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_commit();
    test_arbitration();
    test_last_write_wins();
    test_addr_err();
    test_back_to_back();
    test_timeout();
    test_reset_in_commit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
